// File: rtl/csel_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready backpressure.
// Define CSEL_PIPE_SAT_EN to saturate s to the signed limit on overflow.
module csel_pipe_adder #(
   parameter int WIDTH = 16,
   parameter int STG   = 8,
   parameter int BLK   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int NSTG = WIDTH / STG;
   localparam int NBLK = STG / BLK;
   localparam int LST  = NSTG - 1;

   logic             w_stall;
   logic [WIDTH-1:0] w_beff;
   logic             w_c0;

   assign w_beff   = b ^ {WIDTH{sub}};
   assign w_c0     = sub | cin;
   assign w_stall  = out_valid && !out_ready;
   assign in_ready = !w_stall;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      // IW: unresolved operand bits entering this stage (bit 0 is global bit k*STG)
      localparam int IW = WIDTH - k*STG;
      localparam int RW = IW - STG;

      logic [IW-1:0]        w_aIn;
      logic [IW-1:0]        w_bIn;
      logic                 w_cIn;
      logic                 w_vIn;
      logic [STG-1:0]       w_slice;
      logic [(k+1)*STG-1:0] w_sNext;
      logic [(k+1)*STG-1:0] r_s;
      logic                 r_cy;
      logic                 r_vld;

      if (k == 0) begin : g_src
         assign w_aIn   = a;
         assign w_bIn   = w_beff;
         assign w_cIn   = w_c0;
         assign w_vIn   = in_valid;
         assign w_sNext = w_slice;
      end else begin : g_src
         assign w_aIn   = g_stg[k-1].g_hold.r_a;
         assign w_bIn   = g_stg[k-1].g_hold.r_b;
         assign w_cIn   = g_stg[k-1].r_cy;
         assign w_vIn   = g_stg[k-1].r_vld;
         assign w_sNext = {w_slice, g_stg[k-1].r_s};
      end

      for (genvar j = 0; j < NBLK; j++) begin : g_blk
         logic [BLK:0] w_x;
         logic [BLK:0] w_y;
         logic [BLK:0] w_r0;
         logic [BLK:0] w_r1;
         logic         w_ci;
         logic         w_co;

         assign w_x = {1'b0, w_aIn[j*BLK +: BLK]};
         assign w_y = {1'b0, w_bIn[j*BLK +: BLK]};

         if (j == 0) begin : g_ci
            assign w_ci = w_cIn;
         end else begin : g_ci
            assign w_ci = g_blk[j-1].w_co;
         end

         // The very first block sees the carry-in directly, so a plain ripple suffices.
         if (k == 0 && j == 0) begin : g_rip
            assign w_r0 = w_x + w_y + {{BLK{1'b0}}, w_ci};
            assign w_r1 = w_r0;
         end else begin : g_sel
            assign w_r0 = w_x + w_y;
            assign w_r1 = w_x + w_y + {{BLK{1'b0}}, 1'b1};
         end

         assign {w_co, w_slice[j*BLK +: BLK]} = w_ci ? w_r1 : w_r0;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_vld <= 1'b0;
            r_cy  <= 1'b0;
            r_s   <= '0;
         end else if (!w_stall) begin
            r_vld <= w_vIn;
            r_cy  <= g_blk[NBLK-1].w_co;
            r_s   <= w_sNext;
         end
      end

      if (RW > 0) begin : g_hold
         logic [RW-1:0] r_a;
         logic [RW-1:0] r_b;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_a <= '0;
               r_b <= '0;
            end else if (!w_stall) begin
               r_a <= w_aIn[IW-1:STG];
               r_b <= w_bIn[IW-1:STG];
            end
         end
      end else begin : g_last
         // Overflow is resolved alongside the top slice so only one flag bit is kept.
         logic r_ovf;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_ovf <= 1'b0;
            end else if (!w_stall) begin
               r_ovf <= (w_aIn[IW-1] == w_bIn[IW-1]) && (w_slice[STG-1] != w_aIn[IW-1]);
            end
         end
      end
   end

   assign out_valid = g_stg[LST].r_vld;
   assign cout      = g_stg[LST].r_cy;
   assign ovf       = g_stg[LST].g_last.r_ovf;

`ifdef CSEL_PIPE_SAT_EN
   // On overflow the wrapped sign is the inverse of a's sign.
   assign s = ovf ? {~g_stg[LST].r_s[WIDTH-1], {(WIDTH-1){g_stg[LST].r_s[WIDTH-1]}}}
                  : g_stg[LST].r_s;
`else
   assign s = g_stg[LST].r_s;
`endif

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Scoreboard bench for csel_pipe_adder: driver pushes model results, monitor pops and compares.
module tb_csel_pipe_adder;
   localparam int W   = 16;
   localparam int LAT = 2;

   typedef struct {
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
      int           cyc;
      int           stl;
   } expT;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         cout;
   logic         ovf;

   expT q[$];
   int  nChecks  = 0;
   int  nFails   = 0;
   int  cyc      = 0;
   int  stallCnt = 0;
   bit  wasStalled = 0;
   bit  stimDone   = 0;

   csel_pipe_adder #(.WIDTH(W), .STG(8), .BLK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model from integer arithmetic on the operand values.
   function automatic expT model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                 input logic ci, input logic si);
      expT e;
      int ua, ub, ur, sa, sb, sr;
      ua = int'(ai);
      ub = int'(bi);
      sa = $signed(ai);
      sb = $signed(bi);
      if (si) begin
         ur     = ua - ub;
         sr     = sa - sb;
         e.cout = (ua >= ub);
      end else begin
         ur     = ua + ub + int'(ci);
         sr     = sa + sb + int'(ci);
         e.cout = (ur > 65535);
      end
      e.s   = W'(ur & 32'hFFFF);
      e.ovf = (sr > 32767) || (sr < -32768);
`ifdef CSEL_PIPE_SAT_EN
      if (e.ovf) e.s = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
      e.cyc = 0;
      e.stl = 0;
      return e;
   endfunction

   // Scoreboard push: a beat is accepted at the next rising edge.
   always @(negedge clk) begin
      expT e;
      if (!rst && in_valid && in_ready) begin
         e     = model(a, b, cin, sub);
         e.cyc = cyc;
         e.stl = stallCnt;
         q.push_back(e);
      end
   end

   // Monitor: compares every presented result against the head of the scoreboard.
   always @(negedge clk) begin
      expT e;
      if (rst) begin
         wasStalled = 0;
      end else begin
         checkOutput("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
         if (out_valid) begin
            if (q.size() == 0) begin
               checkOutput("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
               e = q[0];
               checkOutput("s", {16'd0, s}, {16'd0, e.s});
               checkOutput("cout", {31'd0, cout}, {31'd0, e.cout});
               checkOutput("ovf", {31'd0, ovf}, {31'd0, e.ovf});
               if (!wasStalled)
                  checkOutput("latency", cyc - e.cyc, LAT + (stallCnt - e.stl));
               if (out_ready) void'(q.pop_front());
            end
            wasStalled = !out_ready;
            if (!out_ready) stallCnt++;
         end else begin
            wasStalled = 0;
         end
      end
   end

   task automatic applyStimulus(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                input logic ci, input logic si);
      int guard = 0;
      a = ai; b = bi; cin = ci; sub = si; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) checkOutput("accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic resetDut();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_s", {16'd0, s}, 32'd0);
      checkOutput("rst_cout", {31'd0, cout}, 32'd0);
      checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic drain();
      int guard = 0;
      while (q.size() > 0 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("drain_left", q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic waitValid();
      int guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!out_valid) checkOutput("wait_valid_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      resetDut();

      applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
      applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
      applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
      applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
      applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b1);
      applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0);
      drain();

      fork
         for (int i = 0; i < 4; i++)
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         begin
            waitValid();
            @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      for (int i = 0; i < 8; i++)
         applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      applyStimulus(16'($urandom), 16'($urandom), 1'b0, 1'b0);
      @(posedge clk);
      #1;
      applyStimulus(16'($urandom), 16'($urandom), 1'b0, 1'b1);
      drain();

      applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
      applyStimulus(16'h3333, 16'h4444, 1'b0, 1'b0);
      resetDut();
      repeat (5) @(posedge clk);
      #1;
      applyStimulus(16'hABCD, 16'h1234, 1'b1, 1'b0);
      drain();

      fork
         begin
            for (int i = 0; i < 150; i++) begin
               applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
            end
            stimDone = 1;
         end
         begin
            while (!stimDone) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end
endmodule
